branch_resolve_unit: RTL

//   Registered branch-resolution stage. Evaluates the branch condition from ALU flags and funct3,

---
 rtl/branch_resolve_unit.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// Registered branch-resolution stage: evaluates the branch condition from ALU flags, checks the
// fetch-stage prediction, and on a mispredict issues a one-cycle redirect plus a flush that is
// held for FLUSH_CYCLES cycles.
// Optional feature macro: BRU_PERF_CNT_EN enables saturating performance counters.
module branch_resolve_unit #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid,
    input  logic             branch,
    input  logic [2:0]       funct3,
    input  logic             zero_flag,
    input  logic             sign_flag,
    input  logic             carry_flag,
    input  logic             overf_flag,
    input  logic             pred_taken,
    input  logic [XLEN-1:0]  pc_target,
    input  logic [XLEN-1:0]  pc_next,
    input  logic             stall,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic             br_taken,
    output logic             illegal_br,
    output logic [CNT_W-1:0] cnt_branches,
    output logic [CNT_W-1:0] cnt_taken,
    output logic [CNT_W-1:0] cnt_mispred,
    input  logic             cnt_clr
);

    localparam int unsigned FcW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FcW-1:0] FcLoad = FcW'(FLUSH_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StFlush} state_e;

    state_e           state_q, state_d;
    logic [FcW-1:0]   fcnt_q, fcnt_d;

    logic             cond_taken;
    logic             cond_illegal;
    logic             accept;
    logic             mispredict;

    logic             redirect_valid_q;
    logic [XLEN-1:0]  redirect_pc_q;
    logic             br_taken_q;
    logic             illegal_q;

    // Decode the branch condition from funct3 and the ALU flags.
    always_comb begin
        cond_taken   = 1'b0;
        cond_illegal = 1'b0;
        case (funct3)
            3'b000:  cond_taken = zero_flag;
            3'b001:  cond_taken = ~zero_flag;
            3'b100:  cond_taken = sign_flag ^ overf_flag;
            3'b101:  cond_taken = ~(sign_flag ^ overf_flag);
            3'b110:  cond_taken = ~carry_flag;
            3'b111:  cond_taken = carry_flag;
            default: cond_illegal = 1'b1;
        endcase
    end

    // Branches arriving during a flush belong to the killed path and are dropped.
    assign accept     = br_valid & branch & ~stall & (state_q == StIdle);
    assign mispredict = accept & (cond_taken != pred_taken);

    // Resolution registers: redirect pulse, corrected PC, outcome and illegal pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            br_taken_q       <= 1'b0;
            illegal_q        <= 1'b0;
        end else begin
            redirect_valid_q <= mispredict;
            illegal_q        <= accept & cond_illegal;
            if (accept) begin
                br_taken_q <= cond_taken;
            end
            if (mispredict) begin
                redirect_pc_q <= cond_taken ? pc_target : pc_next;
            end
        end
    end

    // Flush FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Flush FSM next state; the counter runs regardless of stall.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            StIdle: begin
                if (mispredict) begin
                    state_d = StFlush;
                    fcnt_d  = FcLoad;
                end
            end
            StFlush: begin
                if (fcnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    fcnt_d = fcnt_q - FcW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Flush FSM outputs: flush is asserted for every cycle spent in StFlush.
    always_comb begin
        flush = 1'b0;
        if (state_q == StFlush) begin
            flush = 1'b1;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign br_taken       = br_taken_q;
    assign illegal_br     = illegal_q;

`ifdef BRU_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_branches_q, cnt_taken_q, cnt_mispred_q;

    // Saturating counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_branches_q <= '0;
            cnt_taken_q    <= '0;
            cnt_mispred_q  <= '0;
        end else if (cnt_clr) begin
            cnt_branches_q <= '0;
            cnt_taken_q    <= '0;
            cnt_mispred_q  <= '0;
        end else begin
            if (accept && (cnt_branches_q != '1)) begin
                cnt_branches_q <= cnt_branches_q + CNT_W'(1);
            end
            if (accept && cond_taken && (cnt_taken_q != '1)) begin
                cnt_taken_q <= cnt_taken_q + CNT_W'(1);
            end
            if (mispredict && (cnt_mispred_q != '1)) begin
                cnt_mispred_q <= cnt_mispred_q + CNT_W'(1);
            end
        end
    end

    assign cnt_branches = cnt_branches_q;
    assign cnt_taken    = cnt_taken_q;
    assign cnt_mispred  = cnt_mispred_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;

    assign cnt_branches = '0;
    assign cnt_taken    = '0;
    assign cnt_mispred  = '0;
`endif

endmodule
